// File: rtl/grey_code_pkg.sv
// Shared definitions for the Gray-code converter slice.
//   GREY_WIDTH_DEFAULT : default data width of the converter
//   grey_word_t        : fixed-width carrier used by the helper functions
//   bin2gray()         : reflected binary -> Gray conversion
//   gray2bin()         : Gray -> binary (prefix XOR from the MSB)
// Narrower values are zero-extended into grey_word_t. Leading zeros map to
// leading zeros in both directions, so results truncate back cleanly.
package grey_code_pkg;

  localparam int unsigned GREY_WIDTH_DEFAULT = 8;
  localparam int unsigned GREY_FN_WIDTH      = 32;

  typedef logic [GREY_FN_WIDTH-1:0] grey_word_t;

  function automatic grey_word_t bin2gray(input grey_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic grey_word_t gray2bin(input grey_word_t g);
    grey_word_t b;
    b = '0;
    b[GREY_FN_WIDTH-1] = g[GREY_FN_WIDTH-1];
    for (int unsigned i = GREY_FN_WIDTH - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/grey_code_if.sv
// Data bundle between a binary producer and the Gray converter.
//   bin  : binary value to convert (carries the converter's `bit` input)
//   grey : Gray-coded result
// master : the producer/consumer side (drives bin, observes grey)
// slave  : the converter side (observes bin, drives grey)
interface grey_code_if
  import grey_code_pkg::*;
#(
  parameter int unsigned WIDTH = GREY_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] grey;

  modport master (output bin, input grey);
  modport slave  (input bin, output grey);

endinterface

// File: rtl/grey_code_enc.sv
// Combinational WIDTH-bit binary -> reflected Gray encoder.
//   bin  : binary input
//   grey : grey[WIDTH-1] = bin[WIDTH-1], grey[i] = bin[i+1] ^ bin[i]
// Purely bitwise, so an unknown on bin[i] only reaches grey[i] and grey[i-1].
module grey_enc
  import grey_code_pkg::*;
#(
  parameter int unsigned WIDTH = GREY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] grey
);

  assign grey = bin ^ (bin >> 1);

endmodule

// File: rtl/grey_code.sv
// Binary-to-Gray converter with optional output register.
//   clk        : rising-edge clock (unused when REGISTERED = 0)
//   rst        : asynchronous active-high reset, clears grey (unused when
//                REGISTERED = 0)
//   bus.bin    : binary value to convert
//   bus.grey   : Gray code of bus.bin; one cycle later when REGISTERED = 1,
//                combinational when REGISTERED = 0
module grey_code
  import grey_code_pkg::*;
#(
  parameter int unsigned WIDTH      = GREY_WIDTH_DEFAULT,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  grey_code_if.slave  bus
);

  logic [WIDTH-1:0] enc_grey;

  grey_enc #(.WIDTH(WIDTH)) u_enc (
    .bin  (bus.bin),
    .grey (enc_grey)
  );

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] grey_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        grey_q <= '0;
      end else begin
        grey_q <= enc_grey;
      end
    end

    assign bus.grey = grey_q;
  end else begin : g_comb
    // clk/rst have no role in the bypass build; fold them into a sink.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign bus.grey = enc_grey;
  end

endmodule

// File: tb/tb_grey_code.sv
module tb_grey_code;
  import grey_code_pkg::*;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic clk_run = 1'b0;

  grey_code_if #(.WIDTH(8)) bus_c ();
  grey_code_if #(.WIDTH(8)) bus_r ();
  grey_code_if #(.WIDTH(4)) bus_4 ();

  grey_code #(.WIDTH(8), .REGISTERED(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  grey_code #(.WIDTH(8), .REGISTERED(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  grey_code #(.WIDTH(4), .REGISTERED(1'b1)) dut_4 (.clk(clk), .rst(rst), .bus(bus_4));

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference Gray sequence built by reflect-and-prefix: entry n is the
  // Gray code of binary n.
  int unsigned gtab [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Timing model of the registered instances: each edge captures the input
  // it sees, reset forgets everything until the next edge.
  logic       m_val = 1'b0;
  logic [7:0] m_bin8;
  logic [3:0] m_bin4;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val <= 1'b0;
    end else begin
      m_val  <= 1'b1;
      m_bin8 <= bus_r.bin;
      m_bin4 <= bus_4.bin;
    end
  end

  always @(negedge clk) begin
    check("comb8", 32'(bus_c.grey), gtab[bus_c.bin]);
    check("reg8", 32'(bus_r.grey), m_val ? gtab[m_bin8] : 32'd0);
    check("reg4", 32'(bus_4.grey), m_val ? gtab[m_bin4] : 32'd0);
  end

  initial begin
    logic [7:0] v8;
    logic [7:0] g8;
    logic [7:0] prev_g8;
    logic [3:0] v4;
    logic [7:0] ends_in  [4];
    logic [7:0] ends_out [4];

    gtab[0] = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gtab[(1 << k) + i] = (1 << k) | gtab[(1 << k) - 1 - i];
      end
    end

    check("tab_00", gtab[8'h00], 32'h00);
    check("tab_7f", gtab[8'h7F], 32'h40);
    check("tab_80", gtab[8'h80], 32'hC0);
    check("tab_ff", gtab[8'hFF], 32'h80);
    check("tab_64", gtab[8'h64], 32'h56);
    check("fn_a5", bin2gray(32'hA5), 32'hF7);
    check("fn_inv_d6", gray2bin(32'hD6), 32'h9B);

    bus_c.bin = 8'h00;
    bus_r.bin = 8'h00;
    bus_4.bin = 4'h0;

    // Combinational instance, no clock running.
    for (int i = 0; i < 10; i++) begin
      bus_c.bin = (i % 2 == 0) ? 8'h64 : 8'h9B;
      #1;
      check("comb_toggle", 32'(bus_c.grey), (i % 2 == 0) ? 32'h56 : 32'hD6);
      #99;
    end

    // Asynchronous reset with no clock edge.
    bus_r.bin = 8'hA5;
    bus_4.bin = 4'h5;
    rst = 1'b1;
    #2;
    check("async_rst8", 32'(bus_r.grey), 32'h00);
    check("async_rst4", 32'(bus_4.grey), 32'h0);
    clk_run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_held8", 32'(bus_r.grey), 32'h00);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge8", 32'(bus_r.grey), 32'hF7);
    check("first_edge4", 32'(bus_4.grey), 32'h7);

    // Full sweep with wrap back to zero.
    prev_g8 = '0;
    for (int i = 0; i <= 256; i++) begin
      v8 = 8'(i);
      bus_r.bin = v8;
      bus_c.bin = v8;
      @(posedge clk);
      #1;
      g8 = bus_r.grey;
      check("sweep_decode", gray2bin(32'(g8)), 32'(v8));
      if (i > 0) check("sweep_hamming", $countones(g8 ^ prev_g8), 32'd1);
      prev_g8 = g8;
    end

    // Range ends.
    ends_in  = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    ends_out = '{8'h00, 8'h40, 8'hC0, 8'h80};
    for (int i = 0; i < 4; i++) begin
      bus_r.bin = ends_in[i];
      @(posedge clk);
      #1;
      check("range_end", 32'(bus_r.grey), 32'(ends_out[i]));
    end

    // Mid-stream reset.
    bus_r.bin = 8'h10;
    @(posedge clk);
    #1;
    bus_r.bin = 8'h11;
    @(posedge clk);
    #1;
    bus_r.bin = 8'h12;
    @(posedge clk);
    #1;
    check("stream_12", 32'(bus_r.grey), 32'h1B);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_drop", 32'(bus_r.grey), 32'h00);
    @(posedge clk);
    #1;
    check("mid_rst_hold", 32'(bus_r.grey), 32'h00);
    bus_r.bin = 8'h33;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_release", 32'(bus_r.grey), 32'h00);
    @(posedge clk);
    #1;
    check("after_release", 32'(bus_r.grey), 32'h2A);

    // WIDTH = 4 exhaustive.
    for (int i = 0; i < 16; i++) begin
      v4 = 4'(i);
      bus_4.bin = v4;
      @(posedge clk);
      #1;
      check("w4_exhaustive", 32'(bus_4.grey), bin2gray(32'(v4)));
    end
    check("w4_f", 32'(bus_4.grey), 32'h8);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      bus_c.bin = 8'($urandom);
      bus_r.bin = 8'($urandom);
      bus_4.bin = 4'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grey_code.md
# grey_code

Binary-to-Gray-code converter with a registered output. Each sample of the binary input `bit` is mapped to its reflected Gray code (`g = b ^ (b >> 1)`) and presented on `grey`. It sits at the boundary of counter or position datapaths that feed clock-domain crossings or encoders, where single-bit-change codes are required. A bypass parameter allows a purely combinational instance.

## Interface
Parameters:
- `WIDTH`, default 8: data width in bits, ≥ 2.
- `REGISTERED`, default 1: 1 = output registered (1-cycle latency); 0 = combinational output, and `clk`/`rst` are unused.

Ports:
- `clk`  input  1  the single clock; rising-edge active.
- `rst`  input  1  asynchronous, active-high reset.
- `bit`  input  WIDTH  binary value to convert (unsigned).
- `grey`  output  WIDTH  Gray-coded value of `bit`.

## Operation
- Conversion is `grey[WIDTH-1] = bit[WIDTH-1]`, and `grey[i] = bit[i+1] ^ bit[i]` for i = 0 … WIDTH-2.
- The function is purely bitwise: no carries, no saturation, no state other than the output register.
- All 2^WIDTH input codes are legal, and the mapping is a bijection.
- Codes at the ends of the range, for WIDTH = 8:
  - 0x00 → 0x00
  - 0xFF → 0x80
  - 0x7F → 0x40
  - 0x80 → 0xC0
- Consecutive binary values (including the wrap 0xFF → 0x00) give outputs that differ in exactly one bit.
- X or Z on any `bit[i]` propagates only to `grey[i]` and `grey[i-1]`.

## Timing
- REGISTERED = 1:
  - `grey` updates on each rising `clk` edge with the converted value of `bit` sampled at that edge. Latency is 1 cycle and throughput is one value per cycle.
  - While `rst` = 1, `grey` = 0, asynchronously; assertion takes effect immediately, with no clock needed.
  - On the first rising edge after `rst` deasserts, `grey` takes the value converted from the `bit` sampled at that edge.
  - Reset asserted mid-stream discards the pending conversion. Output is 0 until the first edge after release.
  - Reset and a clock edge at the same time: reset wins.
- REGISTERED = 0:
  - `grey` follows `bit` with combinational delay only.
  - Reset has no effect.
- No handshake. `bit` must meet setup/hold at `clk` when registered.

## Structure
- A shared package holds:
  - default `WIDTH` constant;
  - `bin2gray(logic [WIDTH-1:0])` function;
  - `gray2bin` function (prefix XOR from the MSB), for use by checkers and downstream decoders.
- One sub-module, `grey_enc`: a combinational WIDTH-bit encoder.
- The top level instantiates `grey_enc` and, when REGISTERED = 1, wraps it in a generate-selected output register with async reset.

## Test plan
1. REGISTERED = 0, `bit` = 0x64 → `grey` = 0x56. Invert all bits to 0x9B → `grey` = 0xD6. Toggle every 100 ns for 10 periods; outputs alternate 0x56/0xD6.
2. REGISTERED = 1, `rst` = 1 with `bit` = 0xA5 → `grey` = 0x00 without any clock edge. Release reset → after 1 edge `grey` = 0xF7.
3. Sweep `bit` from 0x00 to 0xFF, one value per cycle, then wrap to 0x00:
   - each `grey` equals `bin2gray(bit)` delayed by 1 cycle;
   - consecutive outputs have Hamming distance 1;
   - `gray2bin(grey)` equals the delayed `bit`.
4. Range ends: 0x00 → 0x00, 0x7F → 0x40, 0x80 → 0xC0, 0xFF → 0x80.
5. Mid-stream reset: stream 0x10, 0x11, 0x12 and assert `rst` between edges → `grey` drops to 0 immediately and stays 0 while `rst` is high. After release the next edge gives the converted value of the current `bit`.
6. WIDTH = 4, REGISTERED = 1: exhaustive 0 to 15 against the reference function; 0xF → 0x8.
